// File: rtl/cpu_clock_ctrl.sv
// Core clock-enable generator: free-running divided ticks, single-step ticks while
// halted, and a sticky breakpoint flag raised by halt requests from the core.
module cpu_clock_ctrl #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  input  logic                 halt_req,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 ce,
  output logic                 running,
  output logic                 brk,
  output logic [CNT_WIDTH-1:0] tick_count
);

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                 state;
  logic   [DIV_WIDTH-1:0] cnt;
  logic                   step_q;
  logic                   step_hold;
  logic                   step_edge;

  // A step level already high while reset was applied stays masked until it drops,
  // so it cannot masquerade as a fresh edge once reset is released.
  assign step_edge = step & ~step_q & ~step_hold;

  // NOTE: every register below is written with <= so all branches see the values
  // from before this edge; mixing in blocking writes would make ordering matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HALTED;
      ce         <= 1'b0;
      running    <= 1'b0;
      brk        <= 1'b0;
      cnt        <= '0;
      tick_count <= '0;
      step_q     <= 1'b0;
      step_hold  <= step;
    end else begin
      step_q    <= step;
      step_hold <= step_hold & step;

      if (halt_req) begin
        brk <= 1'b1;
      end else if (!run) begin
        brk <= 1'b0;
      end

      // NOTE: ce and running default low each cycle; only the branches that
      // issue a tick or stay in RUNNING raise them, which keeps ce single-cycle.
      ce      <= 1'b0;
      running <= 1'b0;

      case (state)
        HALTED: begin
          if (run && !brk && !halt_req) begin
            state   <= RUNNING;
            running <= 1'b1;
            cnt     <= '0;
          end else if (step_edge) begin
            state <= STEPPING;
          end
        end

        RUNNING: begin
          // A halt wins over a terminal count landing on the same edge.
          if (halt_req || !run) begin
            state <= HALTED;
          end else begin
            running <= 1'b1;
            if (cnt >= div) begin
              ce         <= 1'b1;
              cnt        <= '0;
              tick_count <= tick_count + CNT_ONE;
            end else begin
              cnt <= cnt + DIV_ONE;
            end
          end
        end

        STEPPING: begin
          ce         <= 1'b1;
          tick_count <= tick_count + CNT_ONE;
          state      <= HALTED;
        end

        default: begin
          state <= HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: directed vector table, hand-built corner sequences and
// randomized traffic compared against a cycle-level behavioural model.
module tb_cpu_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        step;
  logic        halt_req;
  logic [15:0] div;
  logic        ce;
  logic        running;
  logic        brk;
  logic [31:0] tick_count;
  logic        ce_s;
  logic        running_s;
  logic        brk_s;
  logic [3:0]  tick_count_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_clock_ctrl #(.DIV_WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req), .div(div),
    .ce(ce), .running(running), .brk(brk), .tick_count(tick_count)
  );

  // Narrow tick counter instance sharing the same stimulus, used for wrap checks.
  cpu_clock_ctrl #(.DIV_WIDTH(16), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req), .div(div),
    .ce(ce_s), .running(running_s), .brk(brk_s), .tick_count(tick_count_s)
  );

  // Behavioural model: mode 0 = halted, 1 = running, 2 = one-shot step pending.
  int     m_mode;
  int     m_wait;
  longint m_ticks;
  bit     m_ce;
  bit     m_brk;
  bit     m_prev_step;
  bit     m_step_masked;

  task automatic model_edge();
    bit fresh_step;
    bit brk_before;
    if (rst) begin
      m_mode = 0; m_wait = 0; m_ticks = 0; m_ce = 0; m_brk = 0;
      m_prev_step = 0; m_step_masked = step;
      return;
    end
    fresh_step = step && !m_prev_step && !m_step_masked;
    brk_before = m_brk;
    m_ce = 0;
    if (m_mode == 2) begin
      m_ce = 1; m_ticks++; m_mode = 0;
    end else if (m_mode == 1) begin
      if (halt_req || !run) m_mode = 0;
      else if (m_wait >= int'(div)) begin
        m_ce = 1; m_ticks++; m_wait = 0;
      end else m_wait++;
    end else begin
      if (run && !brk_before && !halt_req) begin
        m_mode = 1; m_wait = 0;
      end else if (fresh_step) m_mode = 2;
    end
    if (halt_req) m_brk = 1;
    else if (!run) m_brk = 0;
    m_prev_step   = step;
    m_step_masked = m_step_masked && step;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".ce"}, 64'(ce), 64'(m_ce));
    check({tag, ".running"}, 64'(running), 64'(m_mode == 1));
    check({tag, ".brk"}, 64'(brk), 64'(m_brk));
    check({tag, ".tick_count"}, 64'(tick_count), 64'(m_ticks & 64'hFFFF_FFFF));
    check({tag, ".tick_count4"}, 64'(tick_count_s), 64'(m_ticks & 64'hF));
  endtask

  task automatic set_in(bit r, bit ru, bit st, bit h, int d);
    rst = r; run = ru; step = st; halt_req = h; div = 16'(d);
  endtask

  typedef struct {
    bit          rst, run, step, halt_req;
    int          div;
    bit          ce, running, brk;
    logic [31:0] tc;
  } vec_t;

  function automatic vec_t mk(bit r, bit ru, bit st, bit h, int d,
                              bit c, bit rn, bit b, int t);
    vec_t v;
    v.rst = r; v.run = ru; v.step = st; v.halt_req = h; v.div = d;
    v.ce = c; v.running = rn; v.brk = b; v.tc = 32'(t);
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    // Each row: inputs held across one edge, then outputs expected after it.
    vecs[0]  = mk(1, 0, 0, 0, 3,  0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 3,  0, 1, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 3,  0, 1, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 3,  0, 1, 0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 3,  0, 1, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 3,  1, 1, 0, 1);
    vecs[6]  = mk(0, 1, 0, 0, 3,  0, 1, 0, 1);
    vecs[7]  = mk(0, 1, 0, 0, 3,  0, 1, 0, 1);
    vecs[8]  = mk(0, 1, 0, 0, 3,  0, 1, 0, 1);
    vecs[9]  = mk(0, 1, 0, 0, 3,  1, 1, 0, 2);
    vecs[10] = mk(0, 1, 0, 1, 3,  0, 0, 1, 2);
    vecs[11] = mk(0, 1, 0, 0, 3,  0, 0, 1, 2);
    vecs[12] = mk(0, 0, 0, 0, 3,  0, 0, 0, 2);
    vecs[13] = mk(0, 0, 1, 0, 3,  0, 0, 0, 2);
    vecs[14] = mk(0, 0, 1, 0, 3,  1, 0, 0, 3);
    vecs[15] = mk(0, 0, 1, 0, 3,  0, 0, 0, 3);
    vecs[16] = mk(0, 0, 0, 0, 3,  0, 0, 0, 3);

    set_in(1, 0, 0, 0, 3);
    m_mode = 0; m_wait = 0; m_ticks = 0; m_ce = 0; m_brk = 0;
    m_prev_step = 0; m_step_masked = 0;
    tick();
    check("reset.ce", 64'(ce), 64'd0);
    check("reset.tick_count", 64'(tick_count), 64'd0);

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].rst, vecs[i].run, vecs[i].step, vecs[i].halt_req, vecs[i].div);
      tick();
      check($sformatf("vec%0d.ce", i), 64'(ce), 64'(vecs[i].ce));
      check($sformatf("vec%0d.running", i), 64'(running), 64'(vecs[i].running));
      check($sformatf("vec%0d.brk", i), 64'(brk), 64'(vecs[i].brk));
      check($sformatf("vec%0d.tick_count", i), 64'(tick_count), 64'(vecs[i].tc));
    end

    // Halt at div=0: ce drops right after the halt edge, no restart until run toggles.
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 1, 0, 0, 0); tick();
    tick(); check("halt0.ce_pre", 64'(ce), 64'd1);
    tick(); check("halt0.ce_back2back", 64'(ce), 64'd1);
    set_in(0, 1, 0, 1, 0); tick();
    check("halt0.ce", 64'(ce), 64'd0);
    check("halt0.brk", 64'(brk), 64'd1);
    check("halt0.running", 64'(running), 64'd0);
    set_in(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); check("halt0.no_restart", 64'(running), 64'd0);
    end
    set_in(0, 0, 0, 0, 0); tick(); check("halt0.brk_clear", 64'(brk), 64'd0);
    set_in(0, 1, 0, 0, 0); tick(); check("halt0.restart", 64'(running), 64'd1);
    tick(); check("halt0.restart_ce", 64'(ce), 64'd1);

    // Divide ratio shrinks below the current count: tick on the very next edge.
    set_in(1, 0, 0, 0, 10); tick();
    set_in(0, 1, 0, 0, 10); tick();
    for (int i = 0; i < 7; i++) tick();
    div = 16'd2; tick(); check("divdrop.ce0", 64'(ce), 64'd1);
    tick(); check("divdrop.ce1", 64'(ce), 64'd0);
    tick(); check("divdrop.ce2", 64'(ce), 64'd0);
    tick(); check("divdrop.ce3", 64'(ce), 64'd1);
    check_model("divdrop");

    // Tick counter wrap on the 4-bit instance, then reset mid-run.
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 1, 0, 0, 0); tick();
    for (int i = 0; i < 16; i++) tick();
    check("wrap.tick_count4", 64'(tick_count_s), 64'd0);
    check("wrap.tick_count", 64'(tick_count), 64'd16);
    rst = 1'b1; tick();
    check("rstrun.ce", 64'(ce), 64'd0);
    check("rstrun.running", 64'(running), 64'd0);
    check("rstrun.brk", 64'(brk), 64'd0);
    check("rstrun.tick_count", 64'(tick_count), 64'd0);

    // Step held through reset is not an edge; run held through reset starts at once.
    set_in(1, 0, 1, 0, 2); tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); check("stephold.ce", 64'(ce), 64'd0);
    end
    step = 1'b0; tick(); step = 1'b1; tick(); tick();
    check("stepafter.ce", 64'(ce), 64'd1);
    set_in(1, 1, 0, 0, 2); tick();
    rst = 1'b0; tick(); check("runhold.running", 64'(running), 64'd1);
    check_model("runhold");

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      halt_req = ($urandom_range(0, 39) == 0);
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) div = 16'($urandom_range(0, 6));
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16: width of the divide-ratio input and internal divider counter.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the issued-tick counter.
REQ-003 SHALL have port clk  input  1  single clock, driven by the PLL-generated system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port run  input  1  level; 1 requests free-running ticks, 0 requests halt.
REQ-006 SHALL have port step  input  1  synchronous to clk; a rising edge requests one tick while halted.
REQ-007 SHALL have port halt_req  input  1  breakpoint/halt request from the core, pulse or level.
REQ-008 SHALL have port div  input  DIV_WIDTH  divide ratio N; ticks every N+1 cycles while running.
REQ-009 SHALL have port ce  output  1  registered single-cycle clock-enable tick to the core.
REQ-010 SHALL have port running  output  1  registered; 1 iff state is RUNNING.
REQ-011 SHALL have port brk  output  1  registered; breakpoint-latched flag.
REQ-012 SHALL have port tick_count  output  CNT_WIDTH  registered count of ce pulses issued.

Function
REQ-013 SHALL implement states HALTED, RUNNING, STEPPING; state, ce, cnt, tick_count, brk update only on the clk rising edge.
REQ-014 SHALL detect step rising edge as step=1 and step_q=0, where step_q is step registered one cycle.
REQ-015 SHALL set brk on any cycle halt_req=1, in any state; clear brk on any cycle run=0 and halt_req=0.
REQ-016 HALTED: if run=1, brk=0, halt_req=0 -> RUNNING, cnt<=0; else if step edge -> STEPPING; else stay; ce<=0. run has priority over step.
REQ-017 RUNNING: if halt_req=1 or run=0 -> HALTED, ce<=0, cnt unchanged; halt priority over a coincident terminal count (tick suppressed).
REQ-018 RUNNING otherwise: if cnt>=div then ce<=1, cnt<=0, else ce<=0, cnt<=cnt+1.
REQ-019 Comparison SHALL be >= so a div decrease below current cnt produces a tick on the next RUNNING cycle; new div takes effect immediately.
REQ-020 STEPPING: ce<=1 unconditionally, -> HALTED; halt_req, run, step ignored except for brk update.
REQ-021 Step edges in RUNNING or STEPPING SHALL be ignored (not queued).
REQ-022 Latency: run sampled high in HALTED at cycle T -> first ce high at cycle T+2+div; step edge at T in HALTED -> ce high at T+2 only.
REQ-023 tick_count SHALL increment on the same edge ce is loaded 1, so it is visible with ce; wraps from 2^CNT_WIDTH-1 to 0.
REQ-024 ce SHALL never be high two consecutive cycles unless div=0 in RUNNING.

Reset
REQ-025 On rst=1 at an edge: state HALTED, ce=0, running=0, brk=0, cnt=0, tick_count=0, step_q=0; rst overrides all inputs.
REQ-026 Reset asserted mid-RUNNING or mid-STEPPING SHALL abort; ce=0 from the cycle after the reset edge, no pending tick issued.
REQ-027 After rst deasserts with run=1 held, RUNNING SHALL be entered on the first non-reset edge; step held high through reset SHALL NOT count as an edge.

Verification
REQ-028 div=3, run 0->1 at T -> ce pulses at T+5, T+9, T+13; running=1 from T+1; tick_count 1,2,3.
REQ-029 Halted, step pulse 1 cycle at T -> single ce at T+2, tick_count+1, running stays 0; step held 10 cycles -> exactly one ce.
REQ-030 Running div=0, halt_req pulse at T -> ce high through T, low from T+1, brk=1, running=0; run kept 1 -> no restart; run 0 then 1 -> restart.
REQ-031 Running div=10 with cnt=7, div changed to 2 -> ce on the next edge, then every 3 cycles.
REQ-032 tick_count preset near wrap (CNT_WIDTH=4, 14 ticks) -> after 16 ticks reads 0; rst mid-run -> all outputs zero next cycle.
